// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared types and sizing for the decoder scan sequencer.
package scan_seq_pkg;

    localparam int NUM_LINES = 4;
    localparam int CODE_W    = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_scan_sequencer_next_line_sel.sv
// Picks the lowest enabled line (first=1) or the next enabled line above code.
module next_line_sel
    import scan_seq_pkg::*;
(
    input  logic [NUM_LINES-1:0] mask,
    input  logic [CODE_W-1:0]    code,
    input  logic                 first,
    output logic [CODE_W-1:0]    next,
    output logic                 none
);

    logic [NUM_LINES-1:0] cand_s;

    // Candidate lines: enabled and (any line at frame start, or above the current one)
    always_comb begin
        for (int k = 0; k < NUM_LINES; k++) begin
            cand_s[k] = mask[k] & (first | (CODE_W'(k) > code));
        end
    end

    // Priority pick of the lowest candidate
    always_comb begin
        next = '0;
        none = 1'b1;
        for (int k = NUM_LINES - 1; k >= 0; k--) begin
            next = cand_s[k] ? CODE_W'(k) : next;
            none = none & ~cand_s[k];
        end
    end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Steps a 2-to-4 decoder through its enabled lines with programmable dwell and gap.
module decoder_scan_sequencer
    import scan_seq_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int GAP_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 mode_cont,
    input  logic [NUM_LINES-1:0] line_mask,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic [GAP_W-1:0]     gap,
    output logic [CODE_W-1:0]    code,
    output logic                 en,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CNT_W = (DWELL_W > GAP_W) ? DWELL_W : GAP_W;

    // Counters hold "cycles remaining after this one", so a dwell of 0 loads the same as 1.
    function automatic logic [CNT_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : CNT_W'(d - DWELL_W'(1));
    endfunction

    state_t                state_r, state_n;
    logic [CODE_W-1:0]     code_r, code_n;
    logic                  en_r, en_n, busy_r, busy_n, done_r, done_n;
    logic [CNT_W-1:0]      cnt_r, cnt_n;
    logic [NUM_LINES-1:0]  mask_r, mask_n;
    logic [DWELL_W-1:0]    dwell_r, dwell_n;
    logic [GAP_W-1:0]      gap_r, gap_n;
    logic                  cont_r, cont_n;

    logic [CODE_W-1:0]     first_idx_s, nxt_idx_s;
    logic                  first_none_s, nxt_none_s;
    logic                  take_adv_s, relatch_s;

    next_line_sel u_first_sel (
        .mask  (line_mask),
        .code  (code_r),
        .first (1'b1),
        .next  (first_idx_s),
        .none  (first_none_s)
    );

    next_line_sel u_next_sel (
        .mask  (mask_r),
        .code  (code_r),
        .first (1'b0),
        .next  (nxt_idx_s),
        .none  (nxt_none_s)
    );

    // Next-state and next-output logic
    always_comb begin
        state_n    = state_r;
        code_n     = code_r;
        en_n       = en_r;
        busy_n     = busy_r;
        done_n     = 1'b0;
        cnt_n      = cnt_r;
        mask_n     = mask_r;
        dwell_n    = dwell_r;
        gap_n      = gap_r;
        cont_n     = cont_r;
        take_adv_s = 1'b0;
        relatch_s  = 1'b0;

        case (state_r)
            IDLE: begin
                en_n   = 1'b0;
                busy_n = 1'b0;
                if (start && !stop && !first_none_s) begin
                    relatch_s = 1'b1;
                    state_n   = ACTIVE;
                    code_n    = first_idx_s;
                    en_n      = 1'b1;
                    busy_n    = 1'b1;
                    cnt_n     = dwell_load(dwell);
                end else begin
                    state_n = IDLE;
                end
            end
            ACTIVE: begin
                if (stop) begin
                    state_n = IDLE;
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                end else if (cnt_r != '0) begin
                    cnt_n = cnt_r - CNT_W'(1);
                end else if (gap_r != '0) begin
                    state_n = GAP;
                    en_n    = 1'b0;
                    cnt_n   = CNT_W'(gap_r) - CNT_W'(1);
                end else begin
                    take_adv_s = 1'b1;
                end
            end
            GAP: begin
                if (stop) begin
                    state_n = IDLE;
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                end else if (cnt_r != '0) begin
                    cnt_n = cnt_r - CNT_W'(1);
                end else begin
                    take_adv_s = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                en_n    = 1'b0;
                busy_n  = 1'b0;
            end
        endcase

        // Line advance, and at frame end either stop or restart from re-latched config
        if (take_adv_s) begin
            if (!nxt_none_s) begin
                state_n = ACTIVE;
                code_n  = nxt_idx_s;
                en_n    = 1'b1;
                cnt_n   = dwell_load(dwell_r);
            end else if (cont_r && !first_none_s) begin
                done_n    = 1'b1;
                relatch_s = 1'b1;
                state_n   = ACTIVE;
                code_n    = first_idx_s;
                en_n      = 1'b1;
                cnt_n     = dwell_load(dwell);
            end else begin
                done_n  = 1'b1;
                state_n = IDLE;
                en_n    = 1'b0;
                busy_n  = 1'b0;
            end
        end else begin
            done_n = 1'b0;
        end

        if (relatch_s) begin
            mask_n  = line_mask;
            dwell_n = dwell;
            gap_n   = gap;
            cont_n  = mode_cont;
        end else begin
            cont_n = cont_r;
        end
    end

    // State, counter, latched configuration and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            code_r  <= '0;
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= '0;
            mask_r  <= '0;
            dwell_r <= '0;
            gap_r   <= '0;
            cont_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            code_r  <= code_n;
            en_r    <= en_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
            cnt_r   <= cnt_n;
            mask_r  <= mask_n;
            dwell_r <= dwell_n;
            gap_r   <= gap_n;
            cont_r  <= cont_n;
        end
    end

    assign code       = code_r;
    assign en         = en_r;
    assign busy       = busy_r;
    assign frame_done = done_r;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Scoreboard bench: stimulus queues expected en/frame_done events, a negedge monitor checks them.
module tb_decoder_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode_cont = 1'b0;
    logic [3:0] line_mask = 4'd0;
    logic [7:0] dwell = 8'd0;
    logic [3:0] gap = 4'd0;
    logic [1:0] code;
    logic       en;
    logic       busy;
    logic       frame_done;

    decoder_scan_sequencer #(.DWELL_W(8), .GAP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode_cont  (mode_cont),
        .line_mask  (line_mask),
        .dwell      (dwell),
        .gap        (gap),
        .code       (code),
        .en         (en),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit done;
        int code;
        bit busy;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    bit  mon_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int c, input bit d, input int cd, input bit b);
        ev_t e;
        e.cyc = c; e.done = d; e.code = cd; e.busy = b;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Expected events of a single frame whose start is presented during cycle t0
    task automatic push_frame(input int t0, input logic [3:0] m, input int dw, input int gp,
                              input bit done_busy, output int t_end);
        int t;
        int d;
        t = t0 + 1;
        d = (dw == 0) ? 1 : dw;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                for (int i = 0; i < d; i++) begin
                    push(t, 1'b0, k, 1'b1);
                    t++;
                end
                t += gp;
            end
        end
        push(t, 1'b1, 0, done_busy);
        t_end = t;
    endtask

    task automatic do_start(input logic [3:0] m, input int dw, input int gp, input bit cont,
                            output int t0);
        line_mask = m;
        dwell     = 8'(dw);
        gap       = 4'(gp);
        mode_cont = cont;
        start     = 1'b1;
        t0        = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic expect_ev(input bit d);
        ev_t e;
        if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: got %s code=%0d at cycle %0d, expected nothing",
                     d ? "frame_done" : "en", code, cyc);
        end else begin
            e = q.pop_front();
            check(d ? "done_cycle" : "line_cycle", cyc, e.cyc);
            check("event_kind", int'(d), int'(e.done));
            if (!d) check("line_code", int'(code), e.code);
            check("event_busy", int'(busy), int'(e.busy));
        end
    endtask

    // Monitor: every frame_done or en cycle must match the next queued event
    always @(negedge clk) begin
        if (mon_on) begin
            if (frame_done === 1'b1) expect_ev(1'b1);
            if (en === 1'b1) expect_ev(1'b0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int te;

        rst = 1'b1;
        tick();
        tick();
        check("rst_code", int'(code), 0);
        check("rst_en", int'(en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        rst = 1'b0;
        mon_on = 1'b1;
        tick();

        // Full mask, dwell 2, gap 1, one-shot
        do_start(4'b1111, 2, 1, 1'b0, t0);
        push_frame(t0, 4'b1111, 2, 1, 1'b0, te);
        wait_until(t0 + 12);
        check("gap_busy", int'(busy), 1);
        wait_until(te + 2);
        check("t1_idle_busy", int'(busy), 0);

        // Sparse mask, dwell 0 treated as 1, no gap
        do_start(4'b1010, 0, 0, 1'b0, t0);
        push_frame(t0, 4'b1010, 0, 0, 1'b0, te);
        wait_until(te + 2);

        // Continuous single-line scan, stopped during a gap
        do_start(4'b0001, 1, 2, 1'b1, t0);
        push(t0 + 1, 1'b0, 0, 1'b1);
        push(t0 + 4, 1'b1, 0, 1'b1);
        push(t0 + 4, 1'b0, 0, 1'b1);
        push(t0 + 7, 1'b1, 0, 1'b1);
        push(t0 + 7, 1'b0, 0, 1'b1);
        wait_until(t0 + 8);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("cont_stop_en", int'(en), 0);
        check("cont_stop_busy", int'(busy), 0);
        wait_until(t0 + 20);

        // Stop while line 2 is active
        do_start(4'b1111, 5, 0, 1'b0, t0);
        for (int i = 1; i <= 5; i++) push(t0 + i, 1'b0, 0, 1'b1);
        for (int i = 6; i <= 10; i++) push(t0 + i, 1'b0, 1, 1'b1);
        push(t0 + 11, 1'b0, 2, 1'b1);
        push(t0 + 12, 1'b0, 2, 1'b1);
        wait_until(t0 + 12);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("act_stop_en", int'(en), 0);
        check("act_stop_busy", int'(busy), 0);
        check("act_stop_code", int'(code), 2);
        wait_until(t0 + 40);

        // Reset in the middle of a gap, then a fresh frame
        do_start(4'b0110, 1, 3, 1'b0, t0);
        push(t0 + 1, 1'b0, 1, 1'b1);
        wait_until(t0 + 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_code", int'(code), 0);
        check("midrst_en", int'(en), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(frame_done), 0);
        tick();
        do_start(4'b0110, 1, 0, 1'b0, t0);
        push_frame(t0, 4'b0110, 1, 0, 1'b0, te);
        wait_until(te + 2);

        // Start with an empty mask is ignored
        do_start(4'b0000, 3, 0, 1'b0, t0);
        wait_until(t0 + 5);
        check("empty_mask_busy", int'(busy), 0);

        // Start and config changes while busy are ignored
        do_start(4'b1111, 1, 0, 1'b0, t0);
        push_frame(t0, 4'b1111, 1, 0, 1'b0, te);
        wait_until(t0 + 2);
        line_mask = 4'b0001;
        dwell     = 8'd7;
        gap       = 4'd3;
        mode_cont = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        wait_until(te + 3);
        check("busy_ignore_busy", int'(busy), 0);
        mode_cont = 1'b0;

        // Stop wins over a simultaneous start
        line_mask = 4'b1111;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        tick();
        tick();
        check("stop_wins_busy", int'(busy), 0);
        check("stop_wins_en", int'(en), 0);

        tick();
        tick();
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
